// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative encrypt/decrypt cores: key_len coding,
// FSM states, GF(2^8) arithmetic, inverse S-box and the bus byte layout.
package aes_pkg;

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned KEY_LEN_W = 3;
  localparam int unsigned RK_IDX_W  = 4;

  localparam logic [KEY_LEN_W-1:0] KEY_LEN_128 = 3'b001;
  localparam logic [KEY_LEN_W-1:0] KEY_LEN_192 = 3'b010;
  localparam logic [KEY_LEN_W-1:0] KEY_LEN_256 = 3'b100;

  localparam logic [RK_IDX_W-1:0] NR_128 = 4'd10;
  localparam logic [RK_IDX_W-1:0] NR_192 = 4'd12;
  localparam logic [RK_IDX_W-1:0] NR_256 = 4'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } state_t;

  // Highest key_len bit wins; 0 marks an invalid selection.
  function automatic logic [RK_IDX_W-1:0] nr_decode(input logic [KEY_LEN_W-1:0] key_len);
    if (key_len[2])      return NR_256;
    else if (key_len[1]) return NR_192;
    else if (key_len[0]) return NR_128;
    else                 return '0;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // x^254 = x^-1 in GF(2^8), built as x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  // Bus byte holding state element (row, col).
  function automatic int byte_idx(input int row, input int col);
    return 4 * row + col;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] rk,
  input  logic               last,
  output logic [BLOCK_W-1:0] result
);

  logic [BLOCK_W-1:0] keyed;

  // Shift, substitute and add the round key.
  always_comb begin
    keyed = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        keyed[8*byte_idx(r, c) +: 8] = inv_sbox(state[8*byte_idx(r, (c - r + 4) % 4) +: 8]);
      end
    end
    keyed = keyed ^ rk;
  end

  // InvMixColumns: row r of each column uses {0e 0b 0d 09} rotated by r.
  always_comb begin
    result = keyed;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          result[8*byte_idx(r, c) +: 8] =
              gf_mul(8'h0e, keyed[8*byte_idx(r, c) +: 8]) ^
              gf_mul(8'h0b, keyed[8*byte_idx((r + 1) % 4, c) +: 8]) ^
              gf_mul(8'h0d, keyed[8*byte_idx((r + 2) % 4, c) +: 8]) ^
              gf_mul(8'h09, keyed[8*byte_idx((r + 3) % 4, c) +: 8]);
        end
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher, one round per clock, 128/192/256-bit keys.
// Define AES_DEC_ABORT_EN to add an abort input that cancels a block in flight.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
`ifdef AES_DEC_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [BLOCK_W-1:0]   ciphertext,
  input  logic [KEY_LEN_W-1:0] key_len,
  output logic [RK_IDX_W-1:0]  rk_idx,
  input  logic [BLOCK_W-1:0]   rk,
  output logic                 in_ready,
  output logic [BLOCK_W-1:0]   plaintext,
  output logic                 out_valid
);

  state_t              state, state_next;
  logic [BLOCK_W-1:0]  state_reg, state_reg_next;
  logic [BLOCK_W-1:0]  plaintext_next;
  logic [BLOCK_W-1:0]  round_out;
  logic [RK_IDX_W-1:0] cnt, cnt_next;
  logic                out_valid_next;
  logic                last;

  aes_inv_round u_round (
    .state  (state_reg),
    .rk     (rk),
    .last   (last),
    .result (round_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      state_reg <= '0;
      cnt       <= '0;
      plaintext <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      state_reg <= state_reg_next;
      cnt       <= cnt_next;
      plaintext <= plaintext_next;
      out_valid <= out_valid_next;
    end
  end

  // Next state: initial key add on accept, then Nr rounds counting cnt down to 0.
  always_comb begin
    state_next     = state;
    state_reg_next = state_reg;
    cnt_next       = cnt;
    plaintext_next = plaintext;
    out_valid_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (key_len != '0)) begin
          state_reg_next = ciphertext ^ rk;
          cnt_next       = RK_IDX_W'(nr_decode(key_len) - 4'd1);
          state_next     = ST_ROUND;
        end
      end
      ST_ROUND: begin
`ifdef AES_DEC_ABORT_EN
        if (abort) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else
`endif
        if (cnt != '0) begin
          state_reg_next = round_out;
          cnt_next       = RK_IDX_W'(cnt - 4'd1);
        end else begin
          plaintext_next = round_out;
          out_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
    endcase
  end

  // In IDLE the first lookup is key Nr for the pending start; in ROUND it is cnt.
  always_comb begin
    in_ready = (state == ST_IDLE);
    rk_idx   = (state == ST_IDLE) ? nr_decode(key_len) : cnt;
    last     = (cnt == '0);
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors plus random blocks produced by a forward-cipher model.
`timescale 1ns/1ps
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [2:0]   key_len = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rkf    [15];
  logic [127:0] rk_bus [15];

  always #5 clk = ~clk;

  assign rk = (rk_idx < 4'd15) ? rk_bus[rk_idx] : '0;

  aes_decrypt_iter dut (
    .clk        (clk),
    .reset      (reset),
`ifdef AES_DEC_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .ciphertext (ciphertext),
    .key_len    (key_len),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .out_valid  (out_valid)
  );

  // Reference model: forward AES over FIPS byte order (byte j = bits [127-8j -: 8]).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] to_bus(input logic [127:0] f);
    logic [127:0] o;
    o = '0;
    for (int j = 0; j < 16; j++) o[8*(4*(j%4) + j/4) +: 8] = f[127-8*j -: 8];
    return o;
  endfunction

  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      rkf[r]    = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk_bus[r] = to_bus(rkf[r]);
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] p, input int nr);
    logic [127:0] s;
    logic [127:0] o;
    logic [7:0]   a [4];
    s = p ^ rkf[0];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int j = 0; j < 16; j++) s[127-8*j -: 8] = sbox_t[s[127-8*j -: 8]];
      for (int j = 0; j < 16; j++)
        o[127-8*j -: 8] = s[127-8*((j%4) + 4*(((j/4) + (j%4)) % 4)) -: 8];
      s = o;
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
          for (int r = 0; r < 4; r++)
            s[127-8*(4*c+r) -: 8] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^
                                    a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      s = s ^ rkf[rnd];
    end
    return s;
  endfunction

  function automatic int nr_of(input logic [2:0] kl);
    return kl[2] ? 14 : (kl[1] ? 12 : 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one block in the current cycle and waits (bounded) for its out_valid pulse.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [2:0] kl,
                           input logic [127:0] exp_pt, input bit noise, input bit chk_idx);
    int         lat;
    int         nr;
    logic [3:0] q[$];
    nr = nr_of(kl);
    chk({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1));
    ciphertext = ct;
    key_len    = kl;
    start      = 1'b1;
    #1;
    q.push_back(rk_idx);
    step();
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 40) begin
      q.push_back(rk_idx);
      chk({tag, "_in_ready_busy"}, 128'(in_ready), 128'(0));
      if (noise) begin
        start      = 1'($urandom);
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        key_len    = 3'($urandom);
      end
      step();
      lat++;
    end
    start   = 1'b0;
    key_len = kl;
    chk({tag, "_latency"}, 128'(lat), 128'(nr + 1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_plaintext"}, plaintext, exp_pt);
    if (chk_idx) begin
      chk({tag, "_rk_idx_count"}, 128'(q.size()), 128'(nr + 1));
      for (int i = 0; i < q.size() && i <= nr; i++)
        chk({tag, "_rk_idx_seq"}, 128'(q[i]), 128'(nr - i));
    end
  endtask

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pt;
    logic [127:0] prev;
    logic [255:0] key;
    logic [2:0]   kl;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = ginv(8'(i));
      sbox_t[i] = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    end

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_plaintext", plaintext, 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(0));
    reset = 1'b0;
    step();

    // FIPS-197 known answers
    expand(KEY128, 10);
    run_block("aes128", to_bus(CT128), 3'b001, to_bus(PT_FIPS), 1'b0, 1'b1);
    step();
    chk("aes128_pulse_once", 128'(out_valid), 128'(0));
    expand(KEY192, 12);
    run_block("aes192", to_bus(CT192), 3'b010, to_bus(PT_FIPS), 1'b0, 1'b0);
    step();
    expand(KEY256, 14);
    run_block("aes256", to_bus(CT256), 3'b100, to_bus(PT_FIPS), 1'b0, 1'b1);

    // Back-to-back: noisy first block, second start in the out_valid cycle
    step();
    expand(KEY128, 10);
    run_block("b2b_first", to_bus(CT128), 3'b001, to_bus(PT_FIPS), 1'b1, 1'b0);
    pt = {$urandom, $urandom, $urandom, $urandom};
    run_block("b2b_second", to_bus(enc(pt, 10)), 3'b001, to_bus(pt), 1'b0, 1'b0);
    prev = to_bus(pt);

    // Invalid key_len is ignored
    key_len    = 3'b000;
    start      = 1'b1;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      step();
      chk("badlen_in_ready", 128'(in_ready), 128'(1));
      chk("badlen_out_valid", 128'(out_valid), 128'(0));
    end
    start = 1'b0;
    chk("badlen_plaintext", plaintext, prev);

    // Reset in cycle 5 of an AES-256 block
    expand(KEY256, 14);
    ciphertext = to_bus(CT256);
    key_len    = 3'b100;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_plaintext", plaintext, 128'(0));
    for (int i = 0; i < 16; i++) begin
      step();
      chk("midrst_no_valid", 128'(out_valid), 128'(0));
    end
    run_block("after_rst", to_bus(CT256), 3'b100, to_bus(PT_FIPS), 1'b0, 1'b0);
    step();

`ifdef AES_DEC_ABORT_EN
    // Abort in cycle 5 keeps the previous plaintext
    ciphertext = to_bus(CT256);
    key_len    = 3'b100;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_plaintext", plaintext, to_bus(PT_FIPS));
    for (int i = 0; i < 16; i++) begin
      step();
      chk("abort_no_valid", 128'(out_valid), 128'(0));
    end
`endif

    // Random keys, lengths and blocks against the forward-cipher model
    for (int n = 0; n < 8; n++) begin
      kl  = 3'($urandom_range(1, 7));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key, nr_of(kl));
      run_block("random", to_bus(enc(pt, nr_of(kl))), kl, to_bus(pt), 1'(n % 2), 1'b0);
      if (n % 3 == 2) step();
    end
    step();
    chk("final_out_valid", 128'(out_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
